// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD subtractor.
//   estado_t      : controller state encoding
//   NUEVE         : largest valid BCD digit, also the 9's-complement base
//   DIGITOS_DEF   : default operand width in BCD digits
//   digito_valido : true when a nibble is a legal BCD digit
package bcd_pkg;

    localparam int         DIGITOS_DEF = 4;
    localparam logic [3:0] NUEVE       = 4'd9;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULA = 2'd1,
        CORRIGE = 2'd2,
        FIN     = 2'd3
    } estado_t;

    function automatic logic digito_valido(input logic [3:0] d);
        return (d <= NUEVE);
    endfunction

endpackage

// File: rtl/complemento_9_BCD.sv
// Per-digit 9's-complement cell: c_o = 9 - d_i.
//   d_i : BCD digit (only 0..9 is meaningful)
//   c_o : its 9's complement
module complemento_9_BCD
    import bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] c_o
);

    assign c_o = NUEVE - d_i;

endmodule

// File: rtl/sumador_bcd_digito.sv
// Combinational one-digit BCD adder with decimal carry.
//   x_i, y_i : BCD digits (0..9)
//   cin_i    : carry in
//   s_o      : BCD sum digit
//   cout_o   : decimal carry out (sum exceeded 9)
module sumador_bcd_digito (
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);

    logic [4:0] suma;
    logic [3:0] ajustada;

    assign suma     = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, cin_i};
    // suma is at most 19, so the low nibble minus 10 (mod 16) is exactly suma - 10.
    assign ajustada = suma[3:0] - 4'd10;
    assign cout_o   = (suma > 5'd9);
    assign s_o      = cout_o ? ajustada : suma[3:0];

endmodule

// File: rtl/restador_bcd_serial.sv
// Digit-serial BCD subtractor: resultado = |A - B|, LSD first, one digit per clock.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, honoured only while idle
//   A, B      : packed BCD operands, digit 0 in bits [3:0]
//   resultado : packed BCD magnitude
//   negativo  : A < B
//   error     : an operand digit was > 9
//   ocupado   : computing (CALCULA or CORRIGE)
//   listo     : one-cycle completion pulse
//
// state   | meaning
// REPOSO  | idle, waiting for start
// CALCULA | A + 9's(B) + carry, one digit per cycle
// CORRIGE | negative result: 10's complement of resultado back to magnitude
// FIN     | listo pulse, then back to REPOSO
module restador_bcd_serial
    import bcd_pkg::*;
#(
    parameter int DIGITOS = DIGITOS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*DIGITOS-1:0]   A,
    input  logic [4*DIGITOS-1:0]   B,
    output logic [4*DIGITOS-1:0]   resultado,
    output logic                   negativo,
    output logic                   error,
    output logic                   ocupado,
    output logic                   listo
);

    localparam int             IW      = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam logic [IW-1:0]  ULTIMO  = IW'(DIGITOS - 1);

    estado_t                     estado_q, estado_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic                        carry_q, carry_d;
    logic                        neg_q, neg_d;
    logic                        err_q, err_d;
    logic [DIGITOS-1:0][3:0]     a_q, a_d;
    logic [DIGITOS-1:0][3:0]     b_q, b_d;
    logic [DIGITOS-1:0][3:0]     res_q, res_d;

    logic [3:0] sum_x, comp_in, comp_out, sum_s;
    logic       sum_cout;
    logic       operandos_ok;

    // CORRIGE reuses the adder as 0 + 9's(resultado) + carry.
    always_comb begin
        if (estado_q == CORRIGE) begin
            sum_x   = 4'd0;
            comp_in = res_q[idx_q];
        end else begin
            sum_x   = a_q[idx_q];
            comp_in = b_q[idx_q];
        end
    end

    complemento_9_BCD u_comp (
        .d_i (comp_in),
        .c_o (comp_out)
    );

    sumador_bcd_digito u_sum (
        .x_i    (sum_x),
        .y_i    (comp_out),
        .cin_i  (carry_q),
        .s_o    (sum_s),
        .cout_o (sum_cout)
    );

    always_comb begin
        operandos_ok = 1'b1;
        for (int i = 0; i < DIGITOS; i++) begin
            if (!digito_valido(A[4*i +: 4]) || !digito_valido(B[4*i +: 4])) begin
                operandos_ok = 1'b0;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;

        case (estado_q)
            REPOSO: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    res_d    = '0;
                    neg_d    = 1'b0;
                    err_d    = !operandos_ok;
                    idx_d    = '0;
                    carry_d  = 1'b1;
                    estado_d = CALCULA;
                end
            end
            CALCULA: begin
                // Invalid operands: leave resultado cleared and finish straight away.
                if (err_q) begin
                    estado_d = FIN;
                end else begin
                    res_d[idx_q] = sum_s;
                    carry_d      = sum_cout;
                    if (idx_q == ULTIMO) begin
                        if (sum_cout) begin
                            neg_d    = 1'b0;
                            estado_d = FIN;
                        end else begin
                            neg_d    = 1'b1;
                            idx_d    = '0;
                            carry_d  = 1'b1;
                            estado_d = CORRIGE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            CORRIGE: begin
                res_d[idx_q] = sum_s;
                carry_d      = sum_cout;
                if (idx_q == ULTIMO) begin
                    idx_d    = '0;
                    estado_d = FIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= REPOSO;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
        end
    end

    assign resultado = res_q;
    assign negativo  = neg_q;
    assign error     = err_q;
    assign ocupado   = (estado_q == CALCULA) || (estado_q == CORRIGE);
    assign listo     = (estado_q == FIN);

endmodule

// File: tb/tb_restador_bcd_serial.sv
module tb_restador_bcd_serial;

    localparam int D = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [4*D-1:0]  A, B;
    logic [4*D-1:0]  resultado;
    logic            negativo, error, ocupado, listo;

    int checks  = 0;
    int errores = 0;

    restador_bcd_serial #(.DIGITOS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .resultado (resultado),
        .negativo  (negativo),
        .error     (error),
        .ocupado   (ocupado),
        .listo     (listo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errores++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the decimal values.
    function automatic int bcd2int(input logic [4*D-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] int2bcd(input int v);
        logic [4*D-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic tiene_invalido(input logic [4*D-1:0] a, input logic [4*D-1:0] b);
        logic r = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    task automatic esperar_listo(inout int lat, inout int ocup);
        while (listo !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ocupado === 1'b1) ocup++;
        end
    endtask

    task automatic verificar(input string tag, input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                             input int lat, input int ocup);
        logic            e_err = tiene_invalido(a, b);
        int              va = bcd2int(a);
        int              vb = bcd2int(b);
        logic            e_neg = !e_err && (va < vb);
        logic [4*D-1:0]  e_res = e_err ? '0 : int2bcd(e_neg ? vb - va : va - vb);
        int              e_lat = e_err ? 1 : (e_neg ? 2 * D : D);
        check({tag, "_resultado"}, 32'(resultado), 32'(e_res));
        check({tag, "_negativo"},  32'(negativo),  32'(e_neg));
        check({tag, "_error"},     32'(error),     32'(e_err));
        check({tag, "_latencia"},  32'(lat),       32'(e_lat));
        if (!e_err) check({tag, "_ocupado"}, 32'(ocup), 32'(e_lat));
        @(posedge clk); #1;
        check({tag, "_listo_pulso"}, 32'(listo), 32'd0);
        check({tag, "_retiene"},     32'(resultado), 32'(e_res));
    endtask

    task automatic ejecutar(input string tag, input logic [4*D-1:0] a, input logic [4*D-1:0] b);
        int lat = 0;
        int ocup = 0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        if (ocupado === 1'b1) ocup++;
        esperar_listo(lat, ocup);
        verificar(tag, a, b, lat, ocup);
    endtask

    function automatic logic [4*D-1:0] bcd_aleatorio();
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        int lat;
        int ocup;
        logic vio_listo;

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_resultado", 32'(resultado), 32'd0);
        check("reset_flags", 32'({negativo, error, ocupado, listo}), 32'd0);
        @(negedge clk); rst = 1'b0;

        ejecutar("pos_0532_0127", 16'h0532, 16'h0127);
        ejecutar("neg_0127_0532", 16'h0127, 16'h0532);
        ejecutar("neg_0000_0001", 16'h0000, 16'h0001);
        ejecutar("cero_9999",     16'h9999, 16'h9999);
        ejecutar("pos_9999_0000", 16'h9999, 16'h0000);
        ejecutar("err_a_00A0",    16'h00A0, 16'h0000);
        ejecutar("err_b_000F",    16'h0000, 16'h000F);

        // Second start during CALCULA must be ignored.
        lat = 0; ocup = 0;
        @(negedge clk);
        A = 16'h0532; B = 16'h0127; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ocup++;
        @(posedge clk); #1;
        lat++; ocup++;
        @(negedge clk);
        A = 16'h9000; B = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat++; ocup++;
        esperar_listo(lat, ocup);
        verificar("start_ignorado", 16'h0532, 16'h0127, lat, ocup);
        // Issued one cycle after the listo pulse.
        ejecutar("start_tras_listo", 16'h0127, 16'h0532);

        // Reset on the third CALCULA cycle.
        @(negedge clk);
        A = 16'h1234; B = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_medio_resultado", 32'(resultado), 32'd0);
        check("rst_medio_flags", 32'({negativo, error, ocupado, listo}), 32'd0);
        @(negedge clk); rst = 1'b0;
        vio_listo = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (listo === 1'b1 || ocupado === 1'b1) vio_listo = 1'b1;
        end
        check("rst_medio_sin_listo", 32'(vio_listo), 32'd0);
        ejecutar("tras_rst", 16'h0450, 16'h0981);

        for (int n = 0; n < 25; n++) begin
            ejecutar($sformatf("aleatorio_%0d", n), bcd_aleatorio(), bcd_aleatorio());
        end

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
